// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU controls, mult/div ops, mux selects.
package mips_pkg;

    localparam int unsigned W_DEFAULT = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MFHI  = 3'b101,
        MD_MFLO  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: works on operand magnitudes, one step per cycle,
// applies sign fixups when committing HI/LO.
module md_unit
    import mips_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  md_op_t       md_op,
    input  logic [W-1:0] srca,
    input  logic [W-1:0] srcb,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         stall_md
);

    localparam int unsigned CW = $clog2(W);

    md_state_t        state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     opb;
    logic [W-1:0]     a_orig;
    logic             is_mult_q, div_zero, neg_q, neg_r;

    logic             start, is_mult, is_signed;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum, rem_sh, rem_diff;
    logic [2*W-1:0]   mul_next, div_next, prod_fin;
    logic [W-1:0]     hi_fin, lo_fin;

    assign start     = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                       (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign is_mult   = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign mag_a     = (is_signed && srca[W-1]) ? -srca : srca;
    assign mag_b     = (is_signed && srcb[W-1]) ? -srcb : srcb;

    // Shift-add: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[W-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient bits}
    assign rem_sh   = {acc[2*W-1:W], acc[W-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign div_next = rem_diff[W] ? {rem_sh[W-1:0],   acc[W-2:0], 1'b0}
                                  : {rem_diff[W-1:0], acc[W-2:0], 1'b1};

    assign prod_fin = neg_q ? -acc : acc;

    always_comb begin
        hi_fin = acc[2*W-1:W];
        lo_fin = acc[W-1:0];
        if (is_mult_q) begin
            {hi_fin, lo_fin} = prod_fin;
        end else if (div_zero) begin
            lo_fin = '1;
            hi_fin = a_orig;
        end else begin
            lo_fin = neg_q ? -acc[W-1:0]   : acc[W-1:0];
            hi_fin = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_md  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_BUSY;
                    stall_md  = 1'b1;
                end
            end
            MD_BUSY: begin
                stall_md = 1'b1;
                if (cnt == CW'(W-1)) state_nxt = MD_DONE;
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            opb       <= '0;
            a_orig    <= '0;
            is_mult_q <= 1'b0;
            div_zero  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        acc       <= {{W{1'b0}}, mag_a};
                        opb       <= mag_b;
                        a_orig    <= srca;
                        is_mult_q <= is_mult;
                        div_zero  <= (srcb == '0);
                        neg_q     <= is_signed && (srca[W-1] ^ srcb[W-1]);
                        neg_r     <= is_signed && srca[W-1];
                    end
                end
                MD_BUSY: begin
                    acc <= is_mult_q ? mul_next : div_next;
                    cnt <= cnt + CW'(1);
                end
                MD_DONE: begin
                    hi <= hi_fin;
                    lo <= lo_fin;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select, and HI/LO access
// through the iterative mult/div unit.
module ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   alucontrol_e,
    input  logic         alusrc_e,
    input  logic [1:0]   regdst_e,
    input  logic [2:0]   md_op_e,
    input  logic [W-1:0] rd1_e,
    input  logic [W-1:0] rd2_e,
    input  logic [W-1:0] signimm_e,
    input  logic [4:0]   rt_e,
    input  logic [4:0]   rd_e,
    input  logic [1:0]   forward_a_e,
    input  logic [1:0]   forward_b_e,
    input  logic [W-1:0] aluout_m,
    input  logic [W-1:0] result_w,
    output logic [W-1:0] aluout_e,
    output logic [W-1:0] writedata_e,
    output logic [4:0]   writereg_e,
    output logic         stall_md
);

    md_op_t       md_op;
    logic [W-1:0] srca, srcb, alu_res, hi, lo;

    assign md_op = md_op_t'(md_op_e);

    always_comb begin
        case (forward_a_e)
            FWD_W:   srca = result_w;
            FWD_M:   srca = aluout_m;
            default: srca = rd1_e;
        endcase
        case (forward_b_e)
            FWD_W:   writedata_e = result_w;
            FWD_M:   writedata_e = aluout_m;
            default: writedata_e = rd2_e;
        endcase
    end

    assign srcb = alusrc_e ? signimm_e : writedata_e;

    always_comb begin
        case (alucontrol_e)
            ALU_ADD: alu_res = srca + srcb;
            ALU_SUB: alu_res = srca - srcb;
            ALU_AND: alu_res = srca & srcb;
            ALU_OR:  alu_res = srca | srcb;
            ALU_SLT: alu_res = W'($signed(srca) < $signed(srcb));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (md_op)
            MD_MFHI: aluout_e = hi;
            MD_MFLO: aluout_e = lo;
            default: aluout_e = alu_res;
        endcase
    end

    always_comb begin
        case (regdst_e)
            REGDST_RD: writereg_e = rd_e;
            REGDST_RA: writereg_e = 5'd31;
            default:   writereg_e = rt_e;
        endcase
    end

    md_unit #(.W(W)) u_md (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .srca     (srca),
        .srcb     (srcb),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md)
    );

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, randomized ALU/forwarding, and mult/div sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  alucontrol_e = 3'b010;
    logic        alusrc_e = 1'b0;
    logic [1:0]  regdst_e = 2'b00;
    logic [2:0]  md_op_e = 3'b000;
    logic [31:0] rd1_e = '0, rd2_e = '0, signimm_e = '0;
    logic [4:0]  rt_e = '0, rd_e = '0;
    logic [1:0]  forward_a_e = '0, forward_b_e = '0;
    logic [31:0] aluout_m = '0, result_w = '0;
    logic [31:0] aluout_e, writedata_e;
    logic [4:0]  writereg_e;
    logic        stall_md;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e),
        .regdst_e(regdst_e), .md_op_e(md_op_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .signimm_e(signimm_e), .rt_e(rt_e), .rd_e(rd_e), .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e), .aluout_m(aluout_m), .result_w(result_w),
        .aluout_e(aluout_e), .writedata_e(writedata_e), .writereg_e(writereg_e),
        .stall_md(stall_md)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  alu;
        logic        alusrc;
        logic [1:0]  regdst, fa, fb;
        logic [31:0] rd1, rd2, imm, am, rw;
        logic [4:0]  rt, rd;
        logic [31:0] e_alu, e_wd;
        logic [4:0]  e_wr;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] m_fwd(input logic [1:0] f, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
        if (f == 2'b01) return w;
        if (f == 2'b10) return m;
        return r;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            3'b010: return a + b;
            3'b110: return a - b;
            3'b000: return a & b;
            3'b001: return a | b;
            3'b111: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference mult/div results from 64-bit integer arithmetic
    task automatic m_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            3'b001: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'b010: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'b011: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    // Issue a mult/div, count stall cycles, then read back HI and LO
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int n;
        logic [31:0] ehi, elo;
        m_md(op, a, b, ehi, elo);
        md_op_e = op; rd1_e = a; rd2_e = b;
        forward_a_e = 2'b00; forward_b_e = 2'b00; alusrc_e = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall_md || n >= 100) break;
            n++;
            @(posedge clk); #1;
            rd1_e = $urandom; rd2_e = $urandom; aluout_m = $urandom; result_w = $urandom;
        end
        chk({tag, "_stall_len"}, 32'(n), 32'd33);
        @(posedge clk); #1;
        md_op_e = 3'b101;
        @(negedge clk);
        chk({tag, "_hi"}, aluout_e, ehi);
        @(posedge clk); #1;
        md_op_e = 3'b110;
        @(negedge clk);
        chk({tag, "_lo"}, aluout_e, elo);
        chk({tag, "_stall_after"}, 32'(stall_md), 32'd0);
        @(posedge clk); #1;
        md_op_e = 3'b000;
    endtask

    initial begin
        logic [31:0] ea, eb;
        logic [2:0]  ops[4];
        ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b011; ops[3] = 3'b100;

        //            alu     src  rdst   fa     fb     rd1           rd2           imm           am      rw    rt  rd  e_alu         e_wd          e_wr
        vecs[0] = '{3'b010, 1'b0, 2'b00, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        32'd0,  32'd0, 5'd3, 5'd9, 32'd12,       32'd7,        5'd3};
        vecs[1] = '{3'b110, 1'b0, 2'b01, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        32'd0,  32'd0, 5'd3, 5'd9, 32'hFFFFFFFE, 32'd7,        5'd9};
        vecs[2] = '{3'b111, 1'b0, 2'b11, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,  32'd0, 5'd3, 5'd9, 32'd1,        32'd1,        5'd3};
        vecs[3] = '{3'b010, 1'b0, 2'b10, 2'b10, 2'b01, 32'd5,        32'd7,        32'd0,        32'd100, 32'd3, 5'd3, 5'd9, 32'd103,     32'd3,        5'd31};
        vecs[4] = '{3'b010, 1'b1, 2'b00, 2'b11, 2'b00, 32'h20,       32'd7,        32'hFFFFFFF0, 32'd55, 32'd66, 5'd4, 5'd9, 32'h10,      32'd7,        5'd4};
        vecs[5] = '{3'b000, 1'b0, 2'b01, 2'b00, 2'b11, 32'hF0F01234, 32'h0FF0FFFF, 32'd0,        32'd1,  32'd2, 5'd4, 5'd8, 32'h00F01234, 32'h0FF0FFFF, 5'd8};
        vecs[6] = '{3'b011, 1'b0, 2'b00, 2'b00, 2'b00, 32'd1,        32'd2,        32'd0,        32'd0,  32'd0, 5'd1, 5'd2, 32'd0,        32'd2,        5'd1};
        vecs[7] = '{3'b001, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0F00,     32'h00F0,     32'd0,        32'd0,  32'd0, 5'd1, 5'd2, 32'h0FF0,     32'h00F0,     5'd1};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall_md), 32'd0);
        @(posedge clk); #1 md_op_e = 3'b101;
        @(negedge clk);
        chk("rst_hi", aluout_e, 32'd0);
        @(posedge clk); #1 md_op_e = 3'b110;
        @(negedge clk);
        chk("rst_lo", aluout_e, 32'd0);
        @(posedge clk); #1 md_op_e = 3'b000;

        foreach (vecs[i]) begin
            alucontrol_e = vecs[i].alu; alusrc_e = vecs[i].alusrc; regdst_e = vecs[i].regdst;
            forward_a_e = vecs[i].fa; forward_b_e = vecs[i].fb;
            rd1_e = vecs[i].rd1; rd2_e = vecs[i].rd2; signimm_e = vecs[i].imm;
            aluout_m = vecs[i].am; result_w = vecs[i].rw; rt_e = vecs[i].rt; rd_e = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_alu", i), aluout_e, vecs[i].e_alu);
            chk($sformatf("vec%0d_wd", i), writedata_e, vecs[i].e_wd);
            chk($sformatf("vec%0d_wr", i), 32'(writereg_e), 32'(vecs[i].e_wr));
            @(posedge clk); #1;
        end

        for (int i = 0; i < 150; i++) begin
            alucontrol_e = 3'($urandom); alusrc_e = 1'($urandom); regdst_e = 2'($urandom);
            forward_a_e = 2'($urandom); forward_b_e = 2'($urandom);
            md_op_e = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000;
            rd1_e = $urandom; rd2_e = $urandom; signimm_e = $urandom;
            aluout_m = $urandom; result_w = $urandom; rt_e = 5'($urandom); rd_e = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rd2_e = rd1_e;
            ea = m_fwd(forward_a_e, rd1_e, aluout_m, result_w);
            eb = m_fwd(forward_b_e, rd2_e, aluout_m, result_w);
            @(negedge clk);
            chk($sformatf("rnd%0d_alu", i), aluout_e, m_alu(alucontrol_e, ea, alusrc_e ? signimm_e : eb));
            chk($sformatf("rnd%0d_wd", i), writedata_e, eb);
            chk($sformatf("rnd%0d_wr", i), 32'(writereg_e),
                32'((regdst_e == 2'b01) ? rd_e : (regdst_e == 2'b10) ? 5'd31 : rt_e));
            chk($sformatf("rnd%0d_stall", i), 32'(stall_md), 32'd0);
            @(posedge clk); #1;
        end
        md_op_e = 3'b000; alucontrol_e = 3'b010;

        run_md(3'b001, 32'hFFFFFFFD, 32'd7, "mult_m3x7");
        run_md(3'b100, 32'd100, 32'd7, "divu_100_7");
        run_md(3'b011, 32'hFFFFFFF9, 32'd2, "div_m7_2");
        run_md(3'b011, 32'h80000000, 32'hFFFFFFFF, "div_min_m1");
        run_md(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        run_md(3'b011, 32'd9, 32'd0, "div_9_0");
        run_md(3'b100, 32'hFFFFFFF7, 32'd0, "divu_x_0");

        // Reset during BUSY cycle 10 must abandon the op and clear HI/LO
        run_md(3'b011, 32'd9, 32'd0, "pre_reset");
        md_op_e = 3'b001; rd1_e = 32'd1234; rd2_e = 32'd5678;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1; md_op_e = 3'b000;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_stall", 32'(stall_md), 32'd0);
        @(posedge clk); #1 md_op_e = 3'b101;
        @(negedge clk);
        chk("midrst_hi", aluout_e, 32'd0);
        @(posedge clk); #1 md_op_e = 3'b110;
        @(negedge clk);
        chk("midrst_lo", aluout_e, 32'd0);
        @(posedge clk); #1 md_op_e = 3'b000;
        run_md(3'b001, 32'h12345678, 32'hFEDCBA98, "post_reset_mult");

        for (int i = 0; i < 8; i++) begin
            ea = $urandom;
            eb = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_md(ops[$urandom_range(0, 3)], ea, eb, $sformatf("rnd_md%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
